// File: rtl/boot_pkg.sv
// Shared types for the boot load controller: FSM states, buffered boot word
// and the full byte-enable mask used for boot writes.
package boot_pkg;

  localparam int BOOT_AW = 32;
  localparam int BOOT_DW = 32;
  localparam logic [BOOT_DW/8-1:0] BE_ALL = '1;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_FAULT
  } boot_state_t;

  typedef struct packed {
    logic [BOOT_AW-1:0] addr;
    logic [BOOT_DW-1:0] data;
  } boot_word_t;

endpackage

// File: rtl/boot_word_fifo.sv
// Synchronous FIFO of boot words with a registered head output; a word pushed
// into an empty FIFO is presented on head in the following cycle.
module boot_word_fifo
  import boot_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  boot_word_t data_in,
  output logic       full,
  output logic       empty,
  output boot_word_t head
);

  localparam int PW = $clog2(depth) + 1;

  boot_word_t      mem [depth];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic [PW-2:0]   next_rd_idx;
  logic            do_push;
  logic            do_pop;

  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == PW'(depth));
  assign empty       = (count == '0);
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign next_rd_idx = rd_ptr[PW-2:0] + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[PW-2:0]] <= data_in;
  end

  // head tracks the oldest entry: refilled from storage on pop, or straight
  // from data_in when the pushed word becomes the only entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_pop) begin
        if (count > PW'(1)) head <= mem[next_rd_idx];
        else if (do_push) head <= data_in;
      end else if (empty && do_push) begin
        head <= data_in;
      end
    end
  end

endmodule

// File: rtl/boot_load_controller.sv
// Sequences a parsed hex boot image into memory: holds the CPU in reset during
// a load, buffers words, writes them over the shared port and arbitrates it.
module boot_load_controller
  import boot_pkg::*;
#(
  parameter int address_width = BOOT_AW,
  parameter int data_width    = BOOT_DW,
  parameter int fifo_depth    = 4,
  parameter int release_delay = 16,
  parameter int count_width   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      hex_valid,
  input  logic [address_width-1:0]  hex_address,
  input  logic [data_width-1:0]     hex_data,
  input  logic                      hex_busy,
  input  logic                      hex_error,
  input  logic                      cpu_mem_req,
  input  logic                      cpu_mem_we,
  input  logic [address_width-1:0]  cpu_mem_addr,
  input  logic [data_width-1:0]     cpu_mem_wdata,
  input  logic [data_width/8-1:0]   cpu_mem_be,
  output logic                      cpu_mem_ready,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [address_width-1:0]  mem_addr,
  output logic [data_width-1:0]     mem_wdata,
  output logic [data_width/8-1:0]   mem_be,
  input  logic                      mem_ready,
  output logic                      cpu_reset_n,
  output logic                      boot_active,
  output logic                      boot_error,
  output logic [count_width-1:0]    word_count
);

  localparam int RW = $clog2(release_delay + 1);

  boot_state_t   state;
  boot_state_t   state_next;
  logic [RW-1:0] release_cnt;
  logic          busy_q;
  logic          boot_side;
  logic          xfer;
  logic          fresh_load;
  logic          fifo_push;
  logic          fifo_flush;
  logic          fifo_full;
  logic          fifo_empty;
  boot_word_t    fifo_head;
  boot_word_t    push_word;

  assign boot_side   = (state == ST_LOAD) || (state == ST_DRAIN);
  assign boot_active = boot_side;
  assign xfer        = boot_side && !fifo_empty && mem_ready;
  assign push_word   = '{addr: hex_address, data: hex_data};

  boot_word_fifo #(
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (xfer),
    .flush   (fifo_flush),
    .data_in (push_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  always_comb begin
    state_next = state;
    fifo_push  = 1'b0;
    case (state)
      ST_RUN:   if (hex_busy) state_next = ST_LOAD;
      ST_LOAD: begin
        // A parser error or a push into a full, non-draining buffer aborts the load.
        if (hex_error) begin
          state_next = ST_FAULT;
        end else if (hex_valid && fifo_full && !xfer) begin
          state_next = ST_FAULT;
        end else begin
          fifo_push = hex_valid;
          if (!hex_busy) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hex_busy) state_next = ST_LOAD;
        else if (fifo_empty) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (hex_busy) state_next = ST_LOAD;
        else if (release_cnt <= RW'(1)) state_next = ST_RUN;
      end
      ST_FAULT: if (hex_busy && !busy_q) state_next = ST_LOAD;
      default:  state_next = ST_HOLD;
    endcase
    fresh_load = (state_next == ST_LOAD) && !boot_side;
    fifo_flush = fresh_load || (state_next == ST_FAULT);
  end

  always_comb begin
    cpu_mem_ready = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_be        = '0;
    if (state == ST_RUN) begin
      cpu_mem_ready = mem_ready;
      mem_req       = cpu_mem_req;
      mem_we        = cpu_mem_we;
      mem_addr      = cpu_mem_addr;
      mem_wdata     = cpu_mem_wdata;
      mem_be        = cpu_mem_be;
    end else if (boot_side) begin
      mem_req   = !fifo_empty;
      mem_we    = 1'b1;
      mem_addr  = fifo_head.addr;
      mem_wdata = fifo_head.data;
      mem_be    = BE_ALL;
    end
  end

  // cpu_reset_n follows the next state so it is high exactly while in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_HOLD;
      release_cnt <= RW'(release_delay);
      busy_q      <= 1'b0;
      cpu_reset_n <= 1'b0;
      word_count  <= '0;
      boot_error  <= 1'b0;
    end else begin
      state       <= state_next;
      busy_q      <= hex_busy;
      cpu_reset_n <= (state_next == ST_RUN);
      if (fresh_load) begin
        word_count <= '0;
        boot_error <= 1'b0;
      end else begin
        if (xfer && (word_count != '1)) word_count <= word_count + 1'b1;
        if (state_next == ST_FAULT) boot_error <= 1'b1;
      end
      if ((state == ST_DRAIN) && (state_next == ST_HOLD))
        release_cnt <= RW'(release_delay);
      else if ((state == ST_HOLD) && (release_cnt != '0))
        release_cnt <= release_cnt - 1'b1;
    end
  end

endmodule
